// File: rtl/pc_stack_unit.sv
// Program counter and hardware stack pointer unit.
// PC selects among return/jump/ALU targets; SP tracks a bounded stack.
module pc_stack_unit #(
   parameter int              DW          = 32,
   parameter logic [DW-1:0]   RESET_PC    = '0,
   parameter logic [DW-1:0]   STACK_BASE  = 'h0000_00FF,
   parameter logic [DW-1:0]   STACK_LIMIT = 'h0000_00C0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          PCWrite,
   input  logic          PCWriteCond,
   input  logic          ALUZeroCond,
   input  logic          BLTCond,
   input  logic          BGTCond,
   input  logic [1:0]    PCSource,
   input  logic          StackSig,
   input  logic          sp_pop,
   input  logic [DW-1:0] alu_result,
   input  logic [DW-1:0] alu_out,
   input  logic [DW-1:0] mem_data,
   input  logic [25:0]   imm26,
   input  logic          alu_zero,
   input  logic          alu_neg,
   output logic [DW-1:0] pc,
   output logic [DW-1:0] sp,
   output logic          taken,
   output logic          stack_ovf,
   output logic          stack_unf
);

   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] sp_q, sp_d;
   logic          taken_q, taken_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic [DW-1:0] next_pc;
   logic          cond_ok;
   logic          pc_load;
   logic          push;
   logic          pop;

   // Next-PC source mux; jump keeps the upper region bits of the current PC.
   always_comb begin
      next_pc = pc_q;
      unique case (PCSource)
         2'b00:   next_pc = mem_data;
         2'b01:   next_pc = {pc_q[DW-1:26], imm26};
         2'b10:   next_pc = alu_result;
         default: next_pc = alu_out;
      endcase
   end

   // Branch condition evaluation and PC/taken next state.
   always_comb begin
      cond_ok = (PCWriteCond & (ALUZeroCond ? alu_zero : ~alu_zero))
              | (BLTCond & alu_neg)
              | (BGTCond & ~alu_neg & ~alu_zero);
      pc_load = PCWrite | cond_ok;
      pc_d    = pc_q;
      taken_d = taken_q;
      if (pc_load) begin
         pc_d    = next_pc;
         // A plain ALU fetch (PCSource 10) is sequential flow, not a redirect.
         taken_d = cond_ok | (PCWrite & (PCSource != 2'b10));
      end
   end

   // Stack pointer next state with bound checks; errors are sticky.
   always_comb begin
      push  = StackSig & ~sp_pop;
      pop   = sp_pop & ~StackSig;
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (push) begin
         if (sp_q == STACK_LIMIT) begin
            ovf_d = 1'b1;
         end else begin
            sp_d = sp_q - 1'b1;
         end
      end else if (pop) begin
         if (sp_q == STACK_BASE) begin
            unf_d = 1'b1;
         end else begin
            sp_d = sp_q + 1'b1;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         sp_q    <= STACK_BASE;
         taken_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         taken_q <= taken_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign pc        = pc_q;
   assign sp        = sp_q;
   assign taken     = taken_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit.
// Expected states are queued on drive and checked after each edge.
module tb_pc_stack_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCWrite, PCWriteCond, ALUZeroCond;
   logic        BLTCond, BGTCond;
   logic [1:0]  PCSource;
   logic        StackSig, sp_pop;
   logic [31:0] alu_result, alu_out, mem_data;
   logic [25:0] imm26;
   logic        alu_zero, alu_neg;
   logic [31:0] pc, sp;
   logic        taken, stack_ovf, stack_unf;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] sp;
      logic        tk;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   pc_stack_unit dut (
      .clk(clk), .rst(rst),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .ALUZeroCond(ALUZeroCond), .BLTCond(BLTCond),
      .BGTCond(BGTCond), .PCSource(PCSource),
      .StackSig(StackSig), .sp_pop(sp_pop),
      .alu_result(alu_result), .alu_out(alu_out),
      .mem_data(mem_data), .imm26(imm26),
      .alu_zero(alu_zero), .alu_neg(alu_neg),
      .pc(pc), .sp(sp), .taken(taken),
      .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(logic [31:0] p, logic [31:0] s,
                               logic t, logic o, logic u);
      exp_t e;
      e.pc = p; e.sp = s; e.tk = t; e.ovf = o; e.unf = u;
      return e;
   endfunction

   task automatic idle();
      PCWrite = 0; PCWriteCond = 0; ALUZeroCond = 0;
      BLTCond = 0; BGTCond = 0; PCSource = 2'b00;
      StackSig = 0; sp_pop = 0;
      alu_result = '0; alu_out = '0; mem_data = '0; imm26 = '0;
      alu_zero = 0; alu_neg = 0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(string tag, exp_t e);
      chk({tag, ".pc"},  pc,               e.pc);
      chk({tag, ".sp"},  sp,               e.sp);
      chk({tag, ".tk"},  {31'b0, taken},   {31'b0, e.tk});
      chk({tag, ".ovf"}, {31'b0, stack_ovf}, {31'b0, e.ovf});
      chk({tag, ".unf"}, {31'b0, stack_unf}, {31'b0, e.unf});
   endtask

   // Caller sets inputs at a falling edge; one rising edge is applied.
   task automatic tick(string tag, exp_t e);
      exp_t g;
      q.push_back(e);
      @(posedge clk);
      #1;
      g = q.pop_front();
      chk_all(tag, g);
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #3;
      chk_all("reset", mk(32'h0, 32'hFF, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;

      PCWrite = 1; PCSource = 2'b10; alu_result = 32'h1;
      tick("fetch", mk(32'h1, 32'hFF, 0, 0, 0));

      PCWriteCond = 1; ALUZeroCond = 1; alu_zero = 1;
      PCSource = 2'b11; alu_out = 32'h40;
      tick("beq", mk(32'h40, 32'hFF, 1, 0, 0));

      PCWriteCond = 1; ALUZeroCond = 0; alu_zero = 1;
      PCSource = 2'b11; alu_out = 32'h80;
      tick("bne_nt", mk(32'h40, 32'hFF, 1, 0, 0));

      BGTCond = 1; alu_neg = 0; alu_zero = 1;
      PCSource = 2'b11; alu_out = 32'h90;
      tick("bgt_nt", mk(32'h40, 32'hFF, 1, 0, 0));

      BLTCond = 1; alu_neg = 1;
      PCSource = 2'b11; alu_out = 32'h10;
      tick("blt", mk(32'h10, 32'hFF, 1, 0, 0));

      PCWrite = 1; PCSource = 2'b10; alu_result = 32'h0400_0005;
      tick("seq", mk(32'h0400_0005, 32'hFF, 0, 0, 0));

      PCWrite = 1; PCSource = 2'b01; imm26 = 26'h123;
      tick("jump", mk(32'h0400_0123, 32'hFF, 1, 0, 0));

      PCWrite = 1; PCSource = 2'b00; mem_data = 32'h77;
      tick("ret", mk(32'h77, 32'hFF, 1, 0, 0));

      PCWrite = 1; BLTCond = 1; alu_neg = 0;
      PCSource = 2'b10; alu_result = 32'h200;
      tick("uc_cf", mk(32'h200, 32'hFF, 0, 0, 0));

      PCWrite = 1; PCWriteCond = 1; ALUZeroCond = 1; alu_zero = 1;
      PCSource = 2'b10; alu_result = 32'h300;
      tick("uc_ct", mk(32'h300, 32'hFF, 1, 0, 0));

      sp_pop = 1;
      tick("unf", mk(32'h300, 32'hFF, 1, 0, 1));

      for (int i = 1; i <= 63; i++) begin
         StackSig = 1;
         if (i == 1) begin
            PCWrite = 1; PCSource = 2'b10; alu_result = 32'h500;
         end
         tick("push", mk(32'h500, 32'hFF - i, 0, 0, 1));
      end

      StackSig = 1;
      tick("ovf", mk(32'h500, 32'hC0, 0, 1, 1));

      StackSig = 1; sp_pop = 1;
      tick("pushpop", mk(32'h500, 32'hC0, 0, 1, 1));

      sp_pop = 1;
      tick("pop", mk(32'h500, 32'hC1, 0, 1, 1));

      PCWrite = 1; PCSource = 2'b10; alu_result = 32'h999;
      StackSig = 1;
      #2;
      rst = 1'b1;
      #1;
      chk_all("rst_async", mk(32'h0, 32'hFF, 0, 0, 0));
      @(posedge clk);
      #1;
      chk_all("rst_hold", mk(32'h0, 32'hFF, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      idle();

      PCWrite = 1; PCSource = 2'b10; alu_result = 32'h8;
      tick("post_rst", mk(32'h8, 32'hFF, 0, 0, 0));

      PCWriteCond = 1; ALUZeroCond = 0; alu_zero = 0;
      PCSource = 2'b11; alu_out = 32'h24;
      tick("bne_t", mk(32'h24, 32'hFF, 1, 0, 0));

      BGTCond = 1; alu_neg = 0; alu_zero = 0;
      PCSource = 2'b00; mem_data = 32'h3C;
      tick("bgt_t", mk(32'h3C, 32'hFF, 1, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
Parameters:
REQ-001 The block SHALL have parameter DW, default 32, giving the datapath and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value after reset.
REQ-003 The block SHALL have parameter STACK_BASE, default 32'h0000_00FF, giving the empty-stack SP value.
REQ-004 The block SHALL have parameter STACK_LIMIT, default 32'h0000_00C0, giving the lowest legal SP value (full stack).

Ports:
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC update.
- PCWriteCond  in  1  conditional update for BEQ/BNE.
- ALUZeroCond  in  1  selects BEQ (1) or BNE (0) while PCWriteCond=1.
- BLTCond  in  1  conditional update, taken if alu_neg=1.
- BGTCond  in  1  conditional update, taken if alu_neg=0 and alu_zero=0.
- PCSource  in  2  next-PC select.
- StackSig  in  1  push request: decrement SP.
- sp_pop  in  1  pop request: increment SP.
- alu_result  in  DW  combinational ALU output.
- alu_out  in  DW  registered ALU output (branch target from decode).
- mem_data  in  DW  memory read data (return address).
- imm26  in  26  jump immediate.
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU sign flag.
- pc  out  DW  current PC.
- sp  out  DW  current stack pointer.
- taken  out  1  registered: last PC-update cycle changed flow.
- stack_ovf  out  1  sticky overflow.
- stack_unf  out  1  sticky underflow.

Function
REQ-006 The block SHALL compute next PC from PCSource: 00 = mem_data, 01 = {pc[DW-1:26], imm26}, 10 = alu_result, 11 = alu_out.
REQ-007 The block SHALL compute cond_ok = (PCWriteCond & (ALUZeroCond ? alu_zero : ~alu_zero)) | (BLTCond & alu_neg) | (BGTCond & ~alu_neg & ~alu_zero).
REQ-008 The block SHALL load pc with the selected next PC on a rising edge when PCWrite=1 or cond_ok=1; otherwise pc SHALL hold.
REQ-009 When PCWrite=1 and any condition input is also 1, the block SHALL treat the cycle as an unconditional write, with the same next-PC selection.
REQ-010 The block SHALL set taken to 1 at the edge where pc loads with cond_ok=1, or with PCWrite=1 and PCSource != 10. It SHALL clear taken at any other pc load and hold it when pc holds.
REQ-011 For push (StackSig=1, sp_pop=0), the block SHALL set sp to sp-1, unless sp == STACK_LIMIT. In that case sp SHALL hold and stack_ovf SHALL set.
REQ-012 For pop (sp_pop=1, StackSig=0), the block SHALL set sp to sp+1, unless sp == STACK_BASE. In that case sp SHALL hold and stack_unf SHALL set.
REQ-013 When StackSig=1 and sp_pop=1 together, the block SHALL hold sp and leave both error flags unchanged.
REQ-014 stack_ovf and stack_unf SHALL remain set until reset.
REQ-015 PC and SP updates in the same cycle SHALL be independent.
REQ-016 Arithmetic SHALL be DW-bit modulo; the jump SHALL keep pc bits [DW-1:26] of the current PC.
REQ-017 All outputs SHALL be registered, with update latency of one edge.

Reset
REQ-018 While rst=1, asynchronously: pc = RESET_PC, sp = STACK_BASE, taken = 0, stack_ovf = 0, stack_unf = 0.
REQ-019 Reset asserted mid-operation SHALL discard any pending update; after release, the first edge SHALL follow REQ-008..013 normally.

Verification
REQ-020 The bench SHALL cover fetch: rst release, PCWrite=1, PCSource=10, alu_result=1 -> pc=1 after the edge, taken=0.
REQ-021 The bench SHALL cover BEQ/BNE: PCWriteCond=1, ALUZeroCond=1, alu_zero=1, alu_out=0x40 -> pc=0x40, taken=1. The same with ALUZeroCond=0 -> pc unchanged.
REQ-022 The bench SHALL cover BLT/BGT: BGTCond=1, alu_neg=0, alu_zero=1 -> pc holds. BLTCond=1, alu_neg=1, alu_out=0x10 -> pc=0x10.
REQ-023 The bench SHALL cover jump/return: pc=0x0400_0005, PCWrite=1, PCSource=01, imm26=0x123 -> pc=0x0400_0123. Then PCSource=00, mem_data=0x77 -> pc=0x77, taken=1.
REQ-024 The bench SHALL cover stack bounds: 63 pushes from reset -> sp=0xC0. One more push -> sp=0xC0, stack_ovf=1. Then a simultaneous push and pop -> sp=0xC0 unchanged.
REQ-025 The bench SHALL cover underflow/reset: a pop at sp=0xFF -> stack_unf=1, sp=0xFF. Then rst pulsed mid-cycle -> all flags 0 immediately, pc=RESET_PC.
